// File: rtl/ux607_pwmcapport_if.sv
// Capture delivery bundle for the four PWM-capture channels.
// Valid/ready: a word transfers on any cycle where cap_valid[n] & cap_ready[n]; the producer holds data/edge stable while valid waits.
interface ux607_pwmcapport_if #(
    parameter int CNTW = 16
);
    logic [3:0]        cap_valid;
    logic [3:0]        cap_ready;
    logic [4*CNTW-1:0] cap_data;
    logic [3:0]        cap_edge;

    modport master (output cap_valid, output cap_data, output cap_edge, input cap_ready);
    modport slave  (input cap_valid, input cap_data, input cap_edge, output cap_ready);
endinterface

// File: rtl/ux607_pwmcapport.sv
// PWM-pin input capture: sync, optional glitch filter, edge detect, timestamp capture per channel.
// Optional feature macro: UX607_PWMCAP_FILTER_EN (per-channel FW-bit stability filter).
module ux607_pwmcapport #(
    parameter int CNTW = 16,
    parameter int FW   = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                io_pins_pwm_0_i_ival,
    input  logic                io_pins_pwm_1_i_ival,
    input  logic                io_pins_pwm_2_i_ival,
    input  logic                io_pins_pwm_3_i_ival,
    output logic                io_pins_pwm_0_o_oval,
    output logic                io_pins_pwm_1_o_oval,
    output logic                io_pins_pwm_2_o_oval,
    output logic                io_pins_pwm_3_o_oval,
    output logic                io_pins_pwm_0_o_oe,
    output logic                io_pins_pwm_1_o_oe,
    output logic                io_pins_pwm_2_o_oe,
    output logic                io_pins_pwm_3_o_oe,
    output logic                io_pins_pwm_0_o_ie,
    output logic                io_pins_pwm_1_o_ie,
    output logic                io_pins_pwm_2_o_ie,
    output logic                io_pins_pwm_3_o_ie,
    output logic                io_pins_pwm_0_o_pue,
    output logic                io_pins_pwm_1_o_pue,
    output logic                io_pins_pwm_2_o_pue,
    output logic                io_pins_pwm_3_o_pue,
    output logic                io_pins_pwm_0_o_ds,
    output logic                io_pins_pwm_1_o_ds,
    output logic                io_pins_pwm_2_o_ds,
    output logic                io_pins_pwm_3_o_ds,
    input  logic [CNTW-1:0]     io_cnt,
    input  logic [3:0]          cfg_rise_en,
    input  logic [3:0]          cfg_fall_en,
    input  logic [3:0]          cfg_pue,
    input  logic [FW-1:0]       cfg_filt,
    ux607_pwmcapport_if.master  cap,
    output logic [3:0]          cap_ovf,
    input  logic [3:0]          ovf_clr,
    output logic [3:0]          cap_level
);

    assign io_pins_pwm_0_o_oval = 1'b0;
    assign io_pins_pwm_1_o_oval = 1'b0;
    assign io_pins_pwm_2_o_oval = 1'b0;
    assign io_pins_pwm_3_o_oval = 1'b0;
    assign io_pins_pwm_0_o_oe   = 1'b0;
    assign io_pins_pwm_1_o_oe   = 1'b0;
    assign io_pins_pwm_2_o_oe   = 1'b0;
    assign io_pins_pwm_3_o_oe   = 1'b0;
    assign io_pins_pwm_0_o_ie   = 1'b1;
    assign io_pins_pwm_1_o_ie   = 1'b1;
    assign io_pins_pwm_2_o_ie   = 1'b1;
    assign io_pins_pwm_3_o_ie   = 1'b1;
    assign io_pins_pwm_0_o_pue  = cfg_pue[0];
    assign io_pins_pwm_1_o_pue  = cfg_pue[1];
    assign io_pins_pwm_2_o_pue  = cfg_pue[2];
    assign io_pins_pwm_3_o_pue  = cfg_pue[3];
    assign io_pins_pwm_0_o_ds   = 1'b0;
    assign io_pins_pwm_1_o_ds   = 1'b0;
    assign io_pins_pwm_2_o_ds   = 1'b0;
    assign io_pins_pwm_3_o_ds   = 1'b0;

    logic [3:0] pin_raw;
    assign pin_raw = {io_pins_pwm_3_i_ival, io_pins_pwm_2_i_ival,
                      io_pins_pwm_1_i_ival, io_pins_pwm_0_i_ival};

    logic [3:0]        sync1_q, sync2_q, level_q, level_d_q, level_src;
    logic [3:0]        valid_q, valid_d, edge_q, edge_d, ovf_q, ovf_d;
    logic [4*CNTW-1:0] data_q, data_d;

`ifdef UX607_PWMCAP_FILTER_EN
    // filt_q is the filter's own level; cap_level is its registered copy, giving cfg_filt+1 added cycles.
    logic [3:0]    filt_q, filt_d;
    logic [FW-1:0] fcnt_q [4];
    logic [FW-1:0] fcnt_d [4];

    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int n = 0; n < 4; n++) begin
            if (sync2_q[n] == filt_q[n]) begin
                fcnt_d[n] = '0;
            end else if (fcnt_q[n] == cfg_filt) begin
                filt_d[n] = ~filt_q[n];
                fcnt_d[n] = '0;
            end else begin
                fcnt_d[n] = fcnt_q[n] + FW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int n = 0; n < 4; n++) fcnt_q[n] <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign level_src = filt_q;
`else
    logic unused_cfg_filt;
    assign unused_cfg_filt = ^cfg_filt;
    assign level_src       = sync2_q;
`endif

    logic [3:0] rise, fall, evt;
    assign rise = level_q & ~level_d_q;
    assign fall = ~level_q & level_d_q;
    assign evt  = (rise & cfg_rise_en) | (fall & cfg_fall_en);

    always_comb begin
        valid_d = valid_q;
        edge_d  = edge_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        for (int n = 0; n < 4; n++) begin
            if (valid_q[n] && cap.cap_ready[n]) valid_d[n] = 1'b0;
            if (ovf_clr[n]) ovf_d[n] = 1'b0;
            if (evt[n]) begin
                if (!valid_q[n] || cap.cap_ready[n]) begin
                    valid_d[n]             = 1'b1;
                    edge_d[n]              = rise[n];
                    data_d[n*CNTW +: CNTW] = io_cnt;
                end else begin
                    // lost edge: set beats a same-cycle clear
                    ovf_d[n] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            level_d_q <= '0;
            valid_q   <= '0;
            edge_q    <= '0;
            ovf_q     <= '0;
            data_q    <= '0;
        end else begin
            sync1_q   <= pin_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_src;
            level_d_q <= level_q;
            valid_q   <= valid_d;
            edge_q    <= edge_d;
            ovf_q     <= ovf_d;
            data_q    <= data_d;
        end
    end

    assign cap.cap_valid = valid_q;
    assign cap.cap_edge  = edge_q;
    assign cap.cap_data  = data_q;
    assign cap_ovf       = ovf_q;
    assign cap_level     = level_q;

endmodule

// File: tb/tb_ux607_pwmcapport.sv
// Directed bench for ux607_pwmcapport: history-based reference model plus hand-computed capture expectations.
module tb_ux607_pwmcapport;
    localparam int CNTW = 16;
    localparam int FW   = 4;
`ifdef UX607_PWMCAP_FILTER_EN
    localparam int LAT  = 7;
`else
    localparam int LAT  = 3;
`endif

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        pin     = '0;
    logic [3:0]        oval, oe, ie, pue, ds;
    logic [CNTW-1:0]   io_cnt  = '0;
    logic [3:0]        cfg_rise_en = '0;
    logic [3:0]        cfg_fall_en = '0;
    logic [3:0]        cfg_pue     = 4'b1010;
    logic [FW-1:0]     cfg_filt    = '0;
    logic [3:0]        ready       = '0;
    logic [3:0]        cap_ovf, ovf_clr = '0, cap_level;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ux607_pwmcapport_if #(.CNTW(CNTW)) cap_if ();
    assign cap_if.cap_ready = ready;

    ux607_pwmcapport #(.CNTW(CNTW), .FW(FW)) dut (
        .clock(clock), .reset_n(reset_n),
        .io_pins_pwm_0_i_ival(pin[0]), .io_pins_pwm_1_i_ival(pin[1]),
        .io_pins_pwm_2_i_ival(pin[2]), .io_pins_pwm_3_i_ival(pin[3]),
        .io_pins_pwm_0_o_oval(oval[0]), .io_pins_pwm_1_o_oval(oval[1]),
        .io_pins_pwm_2_o_oval(oval[2]), .io_pins_pwm_3_o_oval(oval[3]),
        .io_pins_pwm_0_o_oe(oe[0]), .io_pins_pwm_1_o_oe(oe[1]),
        .io_pins_pwm_2_o_oe(oe[2]), .io_pins_pwm_3_o_oe(oe[3]),
        .io_pins_pwm_0_o_ie(ie[0]), .io_pins_pwm_1_o_ie(ie[1]),
        .io_pins_pwm_2_o_ie(ie[2]), .io_pins_pwm_3_o_ie(ie[3]),
        .io_pins_pwm_0_o_pue(pue[0]), .io_pins_pwm_1_o_pue(pue[1]),
        .io_pins_pwm_2_o_pue(pue[2]), .io_pins_pwm_3_o_pue(pue[3]),
        .io_pins_pwm_0_o_ds(ds[0]), .io_pins_pwm_1_o_ds(ds[1]),
        .io_pins_pwm_2_o_ds(ds[2]), .io_pins_pwm_3_o_ds(ds[3]),
        .io_cnt(io_cnt), .cfg_rise_en(cfg_rise_en), .cfg_fall_en(cfg_fall_en),
        .cfg_pue(cfg_pue), .cfg_filt(cfg_filt), .cap(cap_if),
        .cap_ovf(cap_ovf), .ovf_clr(ovf_clr), .cap_level(cap_level)
    );

    // ---------------- reference model ----------------
    // Histories of per-edge values: pin samples, synchroniser output, filter level, cap_level.
    logic [3:0]        ph_q[$];
    logic [3:0]        sy_q[$];
    logic [3:0]        fl_q[$];
    logic [3:0]        lv_q[$];
    logic [3:0]        m_valid = '0, m_edge = '0, m_ovf = '0;
    logic [4*CNTW-1:0] m_data  = '0;
    bit                model_live = 1'b0;

    function automatic logic [3:0] back(input logic [3:0] q[$], input int d);
        if (d < q.size()) return q[q.size()-1-d];
        return 4'b0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ph_q.delete(); sy_q.delete(); fl_q.delete(); lv_q.delete();
            m_valid = '0; m_edge = '0; m_ovf = '0; m_data = '0;
            model_live = 1'b1;
        end else begin
            logic [3:0] rise, fall, evt, ns, nf, nl, f_old;
            rise = back(lv_q, 0) & ~back(lv_q, 1);
            fall = ~back(lv_q, 0) & back(lv_q, 1);
            evt  = (rise & cfg_rise_en) | (fall & cfg_fall_en);
            for (int n = 0; n < 4; n++) begin
                logic was_full;
                was_full = m_valid[n];
                if (m_valid[n] && ready[n]) m_valid[n] = 1'b0;
                if (evt[n] && (!was_full || ready[n])) begin
                    m_valid[n] = 1'b1;
                    m_edge[n]  = rise[n];
                    m_data[n*CNTW +: CNTW] = io_cnt;
                end
                if (evt[n] && was_full && !ready[n]) m_ovf[n] = 1'b1;
                else if (ovf_clr[n]) m_ovf[n] = 1'b0;
            end
            // filtered level flips after cfg_filt+1 consecutive sync samples disagree with it
            f_old = back(fl_q, 0);
            nf = f_old;
            for (int n = 0; n < 4; n++) begin
                int k;
                k = 0;
                while (k <= int'(cfg_filt) && k < sy_q.size() && back(sy_q, k)[n] != f_old[n]) k++;
                if (k == int'(cfg_filt) + 1) nf[n] = ~f_old[n];
            end
`ifdef UX607_PWMCAP_FILTER_EN
            nl = f_old;
`else
            nl = back(sy_q, 0);
`endif
            ns = back(ph_q, 0);
            ph_q.push_back(pin);
            sy_q.push_back(ns);
            fl_q.push_back(nf);
            lv_q.push_back(nl);
            if (ph_q.size() > 40) begin
                void'(ph_q.pop_front()); void'(sy_q.pop_front());
                void'(fl_q.pop_front()); void'(lv_q.pop_front());
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (model_live) begin
            logic [16+4*CNTW-1:0] act, exp;
            act = {cap_if.cap_valid, cap_if.cap_edge, cap_ovf, cap_level, cap_if.cap_data};
            exp = {m_valid, m_edge, m_ovf, back(lv_q, 0), m_data};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual v/e/o/l/d=%h required=%h", $time, act, exp);
            end
            checks++;
            if ({oval, oe, ie, pue, ds} !== {4'h0, 4'h0, 4'hf, cfg_pue, 4'h0}) begin
                errors++;
                $display("FAIL pads t=%0t actual=%h required=%h", $time,
                         {oval, oe, ie, pue, ds}, {4'h0, 4'h0, 4'hf, cfg_pue, 4'h0});
            end
        end
    end

    // ---------------- scoreboard for channel 2 ----------------
    logic [CNTW:0] exp_q[$];
    logic [CNTW:0] got_q[$];
    bit            sb_en = 1'b0;

    always @(negedge clock) begin
        if (sb_en && reset_n && cap_if.cap_valid[2] && ready[2])
            got_q.push_back({cap_if.cap_edge[2], cap_if.cap_data[2*CNTW +: CNTW]});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_sb(input string name);
        check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        io_cnt = io_cnt + 1'b1;
    endtask

    initial begin
        logic [CNTW-1:0] c;
        int guard;
        // 1: reset with pins toggling
        for (int i = 0; i < 6; i++) begin
            pin = 4'($urandom_range(0, 15));
            tick();
        end
        check("rst_valid", 64'(cap_if.cap_valid), 64'h0);
        check("rst_ovf", 64'(cap_ovf), 64'h0);
        check("rst_ie", 64'(ie), 64'hf);
        check("rst_oe", 64'(oe), 64'h0);
        check("rst_pue", 64'(pue), 64'ha);
        pin = '0;
        tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // 2: rising capture on channel 0, pin changes when io_cnt = 100
        cfg_rise_en = 4'b0001;
        guard = 0;
        while (io_cnt != 16'd100 && guard < 200) begin tick(); guard++; end
        check("cnt_reach_100", 64'(io_cnt), 64'd100);
        pin[0] = 1'b1;
        repeat (3) tick();
        check("t2_not_yet", 64'(cap_if.cap_valid[0]), 64'h0);
        tick();
        check("t2_valid", 64'(cap_if.cap_valid[0]), 64'h1);
        check("t2_data", 64'(cap_if.cap_data[15:0]), 64'd103);
        check("t2_edge", 64'(cap_if.cap_edge[0]), 64'h1);
        ready[0] = 1'b1; tick(); ready[0] = 1'b0; tick();
        check("t2_drained", 64'(cap_if.cap_valid[0]), 64'h0);

        // 3: overflow on channel 1
        cfg_rise_en[1] = 1'b1; cfg_fall_en[1] = 1'b1;
        c = io_cnt;
        pin[1] = 1'b1;
        repeat (10) tick();
        pin[1] = 1'b0;
        repeat (8) tick();
        check("t3_valid", 64'(cap_if.cap_valid[1]), 64'h1);
        check("t3_data_kept", 64'(cap_if.cap_data[31:16]), 64'(16'(c + 16'd3)));
        check("t3_edge", 64'(cap_if.cap_edge[1]), 64'h1);
        check("t3_ovf_set", 64'(cap_ovf[1]), 64'h1);
        ovf_clr[1] = 1'b1; tick(); ovf_clr[1] = 1'b0; tick();
        check("t3_ovf_clr", 64'(cap_ovf[1]), 64'h0);
        ready[1] = 1'b1; tick(); ready[1] = 1'b0; tick();
        check("t3_drained", 64'(cap_if.cap_valid[1]), 64'h0);

        // 4: back-to-back edges every 2 cycles on channel 2, consumer always ready
        cfg_rise_en[2] = 1'b1; cfg_fall_en[2] = 1'b1; ready[2] = 1'b1;
        sb_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({~pin[2], 16'(io_cnt + 16'd3)});
            pin[2] = ~pin[2];
            tick(); tick();
        end
        repeat (6) tick();
        check_sb("t4_b2b");
        check("t4_no_ovf", 64'(cap_ovf[2]), 64'h0);

        // 5: glitch and 6-cycle pulse with cfg_filt = 3
        cfg_filt = 4'd3;
        repeat (4) tick();
        c = io_cnt;
        pin[2] = 1'b1; repeat (3) tick(); pin[2] = 1'b0;
        repeat (16) tick();
`ifndef UX607_PWMCAP_FILTER_EN
        exp_q.push_back({1'b1, 16'(c + 16'd3)});
        exp_q.push_back({1'b0, 16'(c + 16'd6)});
`endif
        check_sb("t5_glitch");
        c = io_cnt;
        pin[2] = 1'b1; repeat (6) tick(); pin[2] = 1'b0;
        repeat (20) tick();
        exp_q.push_back({1'b1, 16'(c + 16'(LAT))});
        exp_q.push_back({1'b0, 16'(c + 16'd6 + 16'(LAT))});
        check_sb("t5_pulse");
        sb_en = 1'b0;
        cfg_filt = 4'd0;
        repeat (4) tick();

        // 6: reset while channel 3 holds a pending capture
        cfg_rise_en[3] = 1'b1;
        pin[3] = 1'b1;
        repeat (6) tick();
        check("t6_pending", 64'(cap_if.cap_valid[3]), 64'h1);
        reset_n = 1'b0;
        tick();
        check("t6_rst_valid", 64'(cap_if.cap_valid), 64'h0);
        check("t6_rst_ovf", 64'(cap_ovf), 64'h0);
        tick();
        reset_n = 1'b1;
        c = io_cnt;
        repeat (3) tick();
        check("t6_not_yet", 64'(cap_if.cap_valid[3]), 64'h0);
        tick();
        check("t6_recap", 64'(cap_if.cap_valid[3]), 64'h1);
        check("t6_data", 64'(cap_if.cap_data[63:48]), 64'(16'(c + 16'd3)));
        check("t6_edge", 64'(cap_if.cap_edge[3]), 64'h1);
        ready[3] = 1'b1; tick(); ready[3] = 1'b0;
        repeat (8) tick();
        check("t6_single", 64'(cap_if.cap_valid[3]), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout reached t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
